// File: rtl/alu_ctrl_decode_stage_pkg.sv
// Shared ISA definitions for the decode stage: opcodes, functs, ALUC codes,
// branch encodings and the decoded bundle carried to execute.
package alu_ctrl_decode_stage_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int CTRL_WIDTH = 4;
    localparam int REG_AW     = 5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] F_SLL = 6'b000000;
    localparam logic [5:0] F_SRL = 6'b000010;
    localparam logic [5:0] F_SRA = 6'b000011;
    localparam logic [5:0] F_ADD = 6'b100000;
    localparam logic [5:0] F_SUB = 6'b100010;
    localparam logic [5:0] F_AND = 6'b100100;
    localparam logic [5:0] F_OR  = 6'b100101;
    localparam logic [5:0] F_XOR = 6'b100110;

    // ALUC codes are shared with the ALU top; keep them in sync there.
    localparam logic [CTRL_WIDTH-1:0] ALUC_ADD = 4'b0000;
    localparam logic [CTRL_WIDTH-1:0] ALUC_SUB = 4'b0100;
    localparam logic [CTRL_WIDTH-1:0] ALUC_XOR = 4'b0010;
    localparam logic [CTRL_WIDTH-1:0] ALUC_AND = 4'b0001;
    localparam logic [CTRL_WIDTH-1:0] ALUC_OR  = 4'b0101;
    localparam logic [CTRL_WIDTH-1:0] ALUC_LUI = 4'b0110;
    localparam logic [CTRL_WIDTH-1:0] ALUC_SLL = 4'b0011;
    localparam logic [CTRL_WIDTH-1:0] ALUC_SRL = 4'b0111;
    localparam logic [CTRL_WIDTH-1:0] ALUC_SRA = 4'b1111;

    typedef enum logic [1:0] {
        BR_NONE = 2'b00,
        BR_BEQ  = 2'b01,
        BR_BNE  = 2'b10,
        BR_J    = 2'b11
    } br_type_e;

    typedef struct packed {
        logic [CTRL_WIDTH-1:0] aluc;
        logic                  asrc;
        logic                  bsrc;
        logic [REG_AW-1:0]     rs;
        logic [REG_AW-1:0]     rt;
        logic [REG_AW-1:0]     rd;
        logic [REG_AW-1:0]     shamt;
        logic [DATA_WIDTH-1:0] imm32;
        logic                  wreg;
        logic                  m2reg;
        logic                  wmem;
        br_type_e              br_type;
        logic [DATA_WIDTH-1:0] pc_plus4;
        logic [DATA_WIDTH-1:0] jtarget;
        logic                  illegal;
    } decode_t;

endpackage

// File: rtl/alu_ctrl_decode_stage_if.sv
// Fetch-side and execute-side handshake bundle of the decode stage.
interface alu_ctrl_decode_stage_if;
    import alu_ctrl_decode_stage_pkg::*;

    logic                  flush;
    logic                  in_valid;
    logic                  in_ready;
    logic [DATA_WIDTH-1:0] instr;
    logic [DATA_WIDTH-1:0] pc;
    logic                  out_valid;
    logic                  out_ready;
    decode_t               dec;

    modport master (output flush, in_valid, instr, pc, out_ready,
                    input  in_ready, out_valid, dec);
    modport slave  (input  flush, in_valid, instr, pc, out_ready,
                    output in_ready, out_valid, dec);
endinterface

// File: rtl/alu_ctrl_decode_stage_comb.sv
// Pure combinational decode of one instruction word plus its PC into the bundle.
module alu_ctrl_decode_comb
    import alu_ctrl_decode_stage_pkg::*;
(
    input  logic [DATA_WIDTH-1:0] instr,
    input  logic [DATA_WIDTH-1:0] pc,
    output decode_t               dec
);
    logic [5:0] op, fn;
    assign op = instr[31:26];
    assign fn = instr[5:0];

    always_comb begin
        dec          = '0;
        dec.aluc     = ALUC_ADD;
        dec.br_type  = BR_NONE;
        dec.rs       = instr[25:21];
        dec.rt       = instr[20:16];
        dec.rd       = instr[20:16];
        dec.shamt    = instr[10:6];
        dec.imm32    = {{16{instr[15]}}, instr[15:0]};
        dec.pc_plus4 = pc + 32'd4;
        dec.jtarget  = {dec.pc_plus4[31:28], instr[25:0], 2'b00};
        case (op)
            OP_RTYPE: begin
                dec.rd   = instr[15:11];
                dec.wreg = 1'b1;
                case (fn)
                    F_ADD: dec.aluc = ALUC_ADD;
                    F_SUB: dec.aluc = ALUC_SUB;
                    F_AND: dec.aluc = ALUC_AND;
                    F_OR:  dec.aluc = ALUC_OR;
                    F_XOR: dec.aluc = ALUC_XOR;
                    F_SLL: begin dec.aluc = ALUC_SLL; dec.asrc = 1'b1; end
                    F_SRL: begin dec.aluc = ALUC_SRL; dec.asrc = 1'b1; end
                    F_SRA: begin dec.aluc = ALUC_SRA; dec.asrc = 1'b1; end
                    default: dec.illegal = 1'b1;
                endcase
            end
            OP_ADDI: begin dec.bsrc = 1'b1; dec.wreg = 1'b1; end
            OP_ANDI: begin
                dec.aluc = ALUC_AND; dec.bsrc = 1'b1; dec.wreg = 1'b1;
                dec.imm32 = {16'b0, instr[15:0]};
            end
            OP_ORI: begin
                dec.aluc = ALUC_OR; dec.bsrc = 1'b1; dec.wreg = 1'b1;
                dec.imm32 = {16'b0, instr[15:0]};
            end
            OP_XORI: begin
                dec.aluc = ALUC_XOR; dec.bsrc = 1'b1; dec.wreg = 1'b1;
                dec.imm32 = {16'b0, instr[15:0]};
            end
            // The ALU does the <<16; the immediate travels zero-extended.
            OP_LUI: begin
                dec.aluc = ALUC_LUI; dec.bsrc = 1'b1; dec.wreg = 1'b1;
                dec.imm32 = {16'b0, instr[15:0]};
            end
            OP_LW:  begin dec.bsrc = 1'b1; dec.wreg = 1'b1; dec.m2reg = 1'b1; end
            OP_SW:  begin dec.bsrc = 1'b1; dec.wmem = 1'b1; end
            OP_BEQ: begin dec.aluc = ALUC_SUB; dec.br_type = BR_BEQ; end
            OP_BNE: begin dec.aluc = ALUC_SUB; dec.br_type = BR_BNE; end
            OP_J:   dec.br_type = BR_J;
            default: dec.illegal = 1'b1;
        endcase
        if (dec.illegal) begin
            dec.aluc = ALUC_ADD;
            dec.asrc = 1'b0;
            dec.wreg = 1'b0;
        end
        // Writes to $0 are dropped so the all-zero word is a true NOP.
        if (dec.rd == '0)
            dec.wreg = 1'b0;
    end
endmodule

// File: rtl/alu_ctrl_decode_stage.sv
// Registered decode stage: decoder feeding a main/skid pair with valid/ready
// on both sides and a synchronous flush.
module alu_ctrl_decode_stage
    import alu_ctrl_decode_stage_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    alu_ctrl_decode_stage_if.slave bus
);
    decode_t dec_c, main_q, skid_q;
    logic    main_v, skid_v, rdy_q;
    logic    main_v_n, skid_v_n;
    logic    ld_main_dec, ld_main_skid, ld_skid;
    logic    accept, retire;

    alu_ctrl_decode_comb u_dec (
        .instr (bus.instr),
        .pc    (bus.pc),
        .dec   (dec_c)
    );

    assign accept = bus.in_valid & rdy_q;
    assign retire = main_v & bus.out_ready;

    // Skid is only ever occupied behind a full main entry, and ready is
    // ~skid_v, so an accept never coincides with an occupied skid.
    always_comb begin
        main_v_n     = main_v;
        skid_v_n     = skid_v;
        ld_main_dec  = 1'b0;
        ld_main_skid = 1'b0;
        ld_skid      = 1'b0;
        if (bus.flush) begin
            main_v_n = 1'b0;
            skid_v_n = 1'b0;
        end else if (retire) begin
            if (skid_v) begin
                ld_main_skid = 1'b1;
                skid_v_n     = 1'b0;
            end else if (accept) begin
                ld_main_dec  = 1'b1;
            end else begin
                main_v_n     = 1'b0;
            end
        end else if (accept) begin
            if (main_v) begin
                ld_skid  = 1'b1;
                skid_v_n = 1'b1;
            end else begin
                ld_main_dec = 1'b1;
                main_v_n    = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_v <= 1'b0;
            skid_v <= 1'b0;
            rdy_q  <= 1'b0;
            main_q <= '0;
            skid_q <= '0;
        end else begin
            main_v <= main_v_n;
            skid_v <= skid_v_n;
            rdy_q  <= ~skid_v_n;
            if (ld_main_dec)
                main_q <= dec_c;
            else if (ld_main_skid)
                main_q <= skid_q;
            if (ld_skid)
                skid_q <= dec_c;
        end
    end

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = main_v;
    assign bus.dec       = main_q;
endmodule

// File: tb/tb_alu_ctrl_decode_stage.sv
// Scoreboard bench for the decode stage: drivers push hand-computed bundles,
// a negedge monitor pops and compares on every retire.
module tb_alu_ctrl_decode_stage;
    import alu_ctrl_decode_stage_pkg::*;

    localparam int BW = $bits(decode_t);

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    alu_ctrl_decode_stage_if bus();

    alu_ctrl_decode_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    decode_t exp_q[$];
    int      tests = 0;
    int      fails = 0;

    task automatic check(input string nm, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic decode_t mk(
        input logic [3:0] aluc, input logic asrc, input logic bsrc,
        input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
        input logic [4:0] shamt, input logic [31:0] imm32,
        input logic wreg, input logic m2reg, input logic wmem, input br_type_e br,
        input logic [31:0] pc4, input logic [31:0] jt, input logic ill);
        decode_t d;
        d.aluc = aluc; d.asrc = asrc; d.bsrc = bsrc;
        d.rs = rs; d.rt = rt; d.rd = rd; d.shamt = shamt; d.imm32 = imm32;
        d.wreg = wreg; d.m2reg = m2reg; d.wmem = wmem; d.br_type = br;
        d.pc_plus4 = pc4; d.jtarget = jt; d.illegal = ill;
        return d;
    endfunction

    // Offer one instruction; the expected bundle is queued once acceptance is certain.
    task automatic send(input logic [31:0] ins, input logic [31:0] pcv, input decode_t e);
        int n = 0;
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.instr    = ins;
        bus.pc       = pcv;
        while (!bus.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            check("send_timeout", BW'(1'b1), BW'(1'b0));
        end else begin
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
    endtask

    // Monitor: compare on every retire, and check hold-stability across stalls.
    initial begin
        decode_t held;
        logic    stalled;
        decode_t e;
        stalled = 1'b0;
        held    = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stalled = 1'b0;
            end else begin
                if (stalled && bus.out_valid)
                    check("stable", bus.dec, held);
                if (bus.out_valid && bus.out_ready) begin
                    if (exp_q.size() == 0) begin
                        check("spurious_out", BW'(bus.dec), BW'(1'b0) ^ BW'(bus.dec) ^ BW'(1'b1));
                    end else begin
                        e = exp_q.pop_front();
                        check("bundle", bus.dec, e);
                    end
                end
                stalled = bus.out_valid & ~bus.out_ready;
                held    = bus.dec;
            end
        end
    end

    task automatic do_reset(input string tag);
        #1 rst = 1'b1;
        #1;
        check({tag, "_out_valid_in_rst"}, BW'(bus.out_valid), BW'(1'b0));
        check({tag, "_in_ready_in_rst"}, BW'(bus.in_ready), BW'(1'b0));
        exp_q.delete();
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (2) @(negedge clk);
        check({tag, "_in_ready_after"}, BW'(bus.in_ready), BW'(1'b1));
        check({tag, "_out_valid_after"}, BW'(bus.out_valid), BW'(1'b0));
        check({tag, "_payload_zero"}, bus.dec, BW'(1'b0));
    endtask

    initial begin
        bus.flush     = 1'b0;
        bus.in_valid  = 1'b0;
        bus.instr     = '0;
        bus.pc        = '0;
        bus.out_ready = 1'b1;

        #3;
        do_reset("reset");

        // Latency: accepted edge -> out_valid before the next edge.
        send(32'h00221820, 32'h0, mk(4'b0000,0,0, 1,2,3, 0, 32'h00001820, 1,0,0, BR_NONE, 32'h4, 32'h00886080, 0));
        @(negedge clk);
        check("latency_out_valid", BW'(bus.out_valid), BW'(1'b1));

        send(32'h000520C3, 32'h4,  mk(4'b1111,1,0, 0,5,4, 3,  32'h000020C3, 1,0,0, BR_NONE, 32'h8,  32'h0014830C, 0));
        send(32'h3C071234, 32'h8,  mk(4'b0110,0,1, 0,7,7, 8,  32'h00001234, 1,0,0, BR_NONE, 32'hC,  32'h001C48D0, 0));
        send(32'h2021FFFF, 32'hC,  mk(4'b0000,0,1, 1,1,1, 31, 32'hFFFFFFFF, 1,0,0, BR_NONE, 32'h10, 32'h0087FFFC, 0));
        send(32'h3421FFFF, 32'h10, mk(4'b0101,0,1, 1,1,1, 31, 32'h0000FFFF, 1,0,0, BR_NONE, 32'h14, 32'h0087FFFC, 0));
        send(32'h00000000, 32'h14, mk(4'b0011,1,0, 0,0,0, 0,  32'h00000000, 0,0,0, BR_NONE, 32'h18, 32'h0, 0));
        send(32'hFC000000, 32'h18, mk(4'b0000,0,0, 0,0,0, 0,  32'h00000000, 0,0,0, BR_NONE, 32'h1C, 32'h0, 1));
        send(32'h8C430008, 32'h20, mk(4'b0000,0,1, 2,3,3, 0,  32'h00000008, 1,1,0, BR_NONE, 32'h24, 32'h010C0020, 0));
        send(32'hAC430008, 32'h24, mk(4'b0000,0,1, 2,3,3, 0,  32'h00000008, 0,0,1, BR_NONE, 32'h28, 32'h010C0020, 0));
        send(32'h08000040, 32'h28, mk(4'b0000,0,0, 0,0,0, 1,  32'h00000040, 0,0,0, BR_J,    32'h2C, 32'h00000100, 0));
        send(32'h1422FFFE, 32'h2C, mk(4'b0100,0,0, 1,2,2, 31, 32'hFFFFFFFE, 0,0,0, BR_BNE,  32'h30, 32'h008BFFF8, 0));
        send(32'h00221821, 32'h30, mk(4'b0000,0,0, 1,2,3, 0,  32'h00001821, 0,0,0, BR_NONE, 32'h34, 32'h00886084, 1));
        send(32'h10220004, 32'h100, mk(4'b0100,0,0, 1,2,2, 0, 32'h00000004, 0,0,0, BR_BEQ,  32'h104, 32'h00880010, 0));
        send(32'h00221820, 32'hFFFFFFFC, mk(4'b0000,0,0, 1,2,3, 0, 32'h00001820, 1,0,0, BR_NONE, 32'h0, 32'h00886080, 0));
        repeat (3) @(negedge clk);
        check("drain_directed", BW'(exp_q.size()), BW'(0));

        // Backpressure: three back-to-back offers against a 2-cycle stall.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        fork
            begin
                send(32'h08000040, 32'h70000000, mk(4'b0000,0,0, 0,0,0, 1, 32'h00000040, 0,0,0, BR_J, 32'h70000004, 32'h70000100, 0));
                send(32'h00221820, 32'h70000004, mk(4'b0000,0,0, 1,2,3, 0, 32'h00001820, 1,0,0, BR_NONE, 32'h70000008, 32'h70886080, 0));
                send(32'h3C071234, 32'h70000008, mk(4'b0110,0,1, 0,7,7, 8, 32'h00001234, 1,0,0, BR_NONE, 32'h7000000C, 32'h701C48D0, 0));
            end
            begin
                repeat (3) @(negedge clk);
                check("bp_in_ready_low", BW'(bus.in_ready), BW'(1'b0));
                @(posedge clk);
                #1 bus.out_ready = 1'b1;
            end
        join
        repeat (4) @(negedge clk);
        check("drain_backpressure", BW'(exp_q.size()), BW'(0));

        // Flush with both entries full and a further instruction offered.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.instr = 32'h00221820; bus.pc = 32'h200;
        @(posedge clk);
        #1 bus.instr = 32'h000520C3; bus.pc = 32'h204;
        @(posedge clk);
        #1 bus.instr = 32'h3C071234; bus.pc = 32'h208; bus.flush = 1'b1;
        @(negedge clk);
        check("flush_full_in_ready", BW'(bus.in_ready), BW'(1'b0));
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
        @(negedge clk);
        check("flush_full_out_valid", BW'(bus.out_valid), BW'(1'b0));
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("flush_full_nothing_out", BW'(bus.out_valid), BW'(1'b0));

        // Flush drops the same-cycle accept while the stage is ready.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.instr = 32'h2021FFFF; bus.pc = 32'h300;
        @(posedge clk);
        #1 bus.instr = 32'h3421FFFF; bus.pc = 32'h304; bus.flush = 1'b1;
        @(negedge clk);
        check("flush_one_in_ready", BW'(bus.in_ready), BW'(1'b1));
        @(posedge clk);
        #1 bus.flush = 1'b0; bus.in_valid = 1'b0;
        bus.out_ready = 1'b1;
        @(negedge clk);
        check("flush_one_out_valid", BW'(bus.out_valid), BW'(1'b0));
        repeat (2) @(negedge clk);
        check("flush_one_nothing_out", BW'(bus.out_valid), BW'(1'b0));

        // Reset while a bundle is stalled at the output.
        @(posedge clk);
        #1 bus.out_ready = 1'b0;
        @(negedge clk);
        bus.in_valid = 1'b1; bus.instr = 32'h8C430008; bus.pc = 32'h400;
        @(posedge clk);
        #1 bus.in_valid = 1'b0;
        @(negedge clk);
        check("pre_rst_out_valid", BW'(bus.out_valid), BW'(1'b1));
        do_reset("midrst");
        bus.out_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("midrst_queue_empty", BW'(exp_q.size()), BW'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not reach its end");
        $fatal(1, "timeout");
    end
endmodule
